// File: rtl/sme_pkg.sv
// Shared constants and feeder state encoding for the string-matching engine.
package sme_pkg;

  localparam int STR_MAX = 32;
  localparam int PAT_MAX = 8;

  localparam logic [7:0] CH_TERM = 8'h0A;
  localparam logic [7:0] CH_STR  = 8'h53;
  localparam logic [7:0] CH_PAT  = 8'h50;

  // SME pattern metacharacters
  localparam logic [7:0] CH_ANY   = 8'h2E;
  localparam logic [7:0] CH_BOL   = 8'h5E;
  localparam logic [7:0] CH_EOL   = 8'h24;
  localparam logic [7:0] CH_STAR  = 8'h2A;
  localparam logic [7:0] CH_SPACE = 8'h20;

  typedef enum logic [2:0] {
    ST_TYPE,
    ST_LOAD,
    ST_DROP,
    ST_PLAY,
    ST_WAIT
  } feed_state_e;

  function automatic logic [5:0] rec_max(input logic is_pat);
    return is_pat ? 6'(PAT_MAX) : 6'(STR_MAX);
  endfunction

endpackage

// File: rtl/sme_feeder_if.sv
// Byte stream in, SME character bus out. A byte transfers on a rising edge
// where in_valid && in_ready; in_ready never depends on in_valid.
interface sme_feeder_if;
  import sme_pkg::*;

  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        sme_valid;
  logic [7:0]  chardata;
  logic        isstring;
  logic        ispattern;
  logic        busy;
  logic        rec_err;
  feed_state_e state;

  modport master (
    output in_data, in_valid, sme_valid,
    input  in_ready, chardata, isstring, ispattern, busy, rec_err, state
  );

  modport slave (
    input  in_data, in_valid, sme_valid,
    output in_ready, chardata, isstring, ispattern, busy, rec_err, state
  );

endinterface

// File: rtl/sme_line_buffer.sv
// 32x8 record buffer: synchronous write, asynchronous read, storage not reset.
module sme_line_buffer (
  input  logic       clk,
  input  logic       we,
  input  logic [4:0] waddr,
  input  logic [7:0] wdata,
  input  logic [4:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem_q [32];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sme_feeder.sv
// Buffers newline-terminated S/P records and replays each one to SME as a
// gap-free burst, holding off input after a pattern until SME reports valid.
module sme_feeder
  import sme_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  sme_feeder_if.slave  bus
);

  feed_state_e state_q, state_d;
  logic [5:0]  len_q, len_d;
  logic [5:0]  rptr_q, rptr_d;
  logic        is_pat_q, is_pat_d;
  logic        str_loaded_q, str_loaded_d;
  logic        pat_since_str_q, pat_since_str_d;
  logic [7:0]  chardata_q, chardata_d;
  logic        isstring_q, isstring_d;
  logic        ispattern_q, ispattern_d;
  logic        rec_err_q, rec_err_d;

  logic        in_ready;
  logic        xfer;
  logic        buf_we;
  logic [4:0]  buf_raddr;
  logic [7:0]  buf_rdata;

  // Gated by reset so the stream is held off while reset is asserted.
  assign in_ready = reset && (state_q == ST_TYPE || state_q == ST_LOAD || state_q == ST_DROP);
  assign xfer     = bus.in_valid && in_ready;

  // Address 0 outside PLAY lets the terminator cycle preload byte 0.
  assign buf_raddr = (state_q == ST_PLAY) ? rptr_q[4:0] : 5'd0;

  sme_line_buffer u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (len_q[4:0]),
    .wdata (bus.in_data),
    .raddr (buf_raddr),
    .rdata (buf_rdata)
  );

  always_comb begin
    state_d         = state_q;
    len_d           = len_q;
    rptr_d          = rptr_q;
    is_pat_d        = is_pat_q;
    str_loaded_d    = str_loaded_q;
    pat_since_str_d = pat_since_str_q;
    chardata_d      = 8'h00;
    isstring_d      = 1'b0;
    ispattern_d     = 1'b0;
    rec_err_d       = 1'b0;
    buf_we          = 1'b0;

    case (state_q)
      ST_TYPE: begin
        if (xfer) begin
          if (bus.in_data == CH_STR) begin
            // A second string before any pattern would be appended by SME.
            if (str_loaded_q && !pat_since_str_q) begin
              rec_err_d = 1'b1;
              state_d   = ST_DROP;
            end else begin
              is_pat_d = 1'b0;
              len_d    = 6'd0;
              state_d  = ST_LOAD;
            end
          end else if (bus.in_data == CH_PAT) begin
            if (!str_loaded_q) begin
              rec_err_d = 1'b1;
              state_d   = ST_DROP;
            end else begin
              is_pat_d = 1'b1;
              len_d    = 6'd0;
              state_d  = ST_LOAD;
            end
          end else if (bus.in_data != CH_TERM) begin
            rec_err_d = 1'b1;
            state_d   = ST_DROP;
          end
        end
      end

      ST_LOAD: begin
        if (xfer) begin
          if (bus.in_data == CH_TERM) begin
            if (len_q != 6'd0) begin
              chardata_d  = buf_rdata;
              isstring_d  = !is_pat_q;
              ispattern_d = is_pat_q;
              rptr_d      = 6'd1;
              state_d     = ST_PLAY;
            end else begin
              state_d = ST_TYPE;
            end
          end else if (len_q == rec_max(is_pat_q)) begin
            rec_err_d = 1'b1;
            state_d   = ST_DROP;
          end else begin
            buf_we = 1'b1;
            len_d  = len_q + 6'd1;
          end
        end
      end

      ST_DROP: begin
        if (xfer && bus.in_data == CH_TERM) state_d = ST_TYPE;
      end

      ST_PLAY: begin
        if (rptr_q != len_q) begin
          chardata_d  = buf_rdata;
          isstring_d  = !is_pat_q;
          ispattern_d = is_pat_q;
          rptr_d      = rptr_q + 6'd1;
        end else if (is_pat_q) begin
          state_d = ST_WAIT;
        end else begin
          str_loaded_d    = 1'b1;
          pat_since_str_d = 1'b0;
          state_d         = ST_TYPE;
        end
      end

      ST_WAIT: begin
        if (bus.sme_valid) begin
          pat_since_str_d = 1'b1;
          state_d         = ST_TYPE;
        end
      end

      default: state_d = ST_TYPE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_TYPE;
      len_q           <= 6'd0;
      rptr_q          <= 6'd0;
      is_pat_q        <= 1'b0;
      str_loaded_q    <= 1'b0;
      pat_since_str_q <= 1'b0;
      chardata_q      <= 8'h00;
      isstring_q      <= 1'b0;
      ispattern_q     <= 1'b0;
      rec_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      len_q           <= len_d;
      rptr_q          <= rptr_d;
      is_pat_q        <= is_pat_d;
      str_loaded_q    <= str_loaded_d;
      pat_since_str_q <= pat_since_str_d;
      chardata_q      <= chardata_d;
      isstring_q      <= isstring_d;
      ispattern_q     <= ispattern_d;
      rec_err_q       <= rec_err_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.chardata  = chardata_q;
  assign bus.isstring  = isstring_q;
  assign bus.ispattern = ispattern_q;
  assign bus.busy      = (state_q != ST_TYPE);
  assign bus.rec_err   = rec_err_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_sme_feeder.sv
// Directed bench for sme_feeder: record framing, bursts, WAIT hold-off,
// sequencing errors and asynchronous reset mid-burst.
module tb_sme_feeder;
  import sme_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sme_feeder_if bus();

  sme_feeder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int strobe_cnt = 0;
  int both_cnt   = 0;
  int err_cnt    = 0;
  int e0, s0;
  logic [7:0] exp_q[$];

  always @(negedge clk) begin
    if (bus.isstring || bus.ispattern) strobe_cnt++;
    if (bus.isstring && bus.ispattern) both_cnt++;
    if (bus.rec_err) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
  endtask

  task automatic send_rec(input string s, input bit stall);
    for (int i = 0; i < s.len(); i++) begin
      if (stall && (i % 2 == 1)) idle(1);
      send_byte(s[i]);
    end
  endtask

  // Called at the cycle right after the terminator was accepted.
  task automatic check_burst(input string tag, input bit is_pat, input int n, input bit inject);
    logic [7:0] exp_b;
    for (int i = 0; i < n; i++) begin
      exp_b = exp_q.pop_front();
      check({tag, "_data"}, 32'(bus.chardata), 32'(exp_b));
      check({tag, "_isstring"}, 32'(bus.isstring), 32'(!is_pat));
      check({tag, "_ispattern"}, 32'(bus.ispattern), 32'(is_pat));
      if (inject) bus.sme_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.sme_valid = 1'b0;
    check({tag, "_end_strobes"}, 32'({bus.isstring, bus.ispattern}), 32'd0);
    check({tag, "_end_data"}, 32'(bus.chardata), 32'd0);
  endtask

  task automatic wait_release(input string tag);
    check({tag, "_wait_ready"}, 32'(bus.in_ready), 32'd0);
    idle(3);
    check({tag, "_wait_hold"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_wait_busy"}, 32'(bus.busy), 32'd1);
    bus.sme_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.sme_valid = 1'b0;
    check({tag, "_release_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_release_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.sme_valid = 1'b0;
    #2 reset = 1'b0;
    idle(2);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_outputs", 32'({bus.chardata, bus.isstring, bus.ispattern, bus.busy, bus.rec_err}), 32'd0);
    reset = 1'b1;
    #1;
    check("rel_in_ready", 32'(bus.in_ready), 32'd1);
    idle(1);

    // Pattern before any string, unknown type, empty record, bare newline.
    s0 = strobe_cnt;
    e0 = err_cnt;
    send_rec("Px\n", 0);
    idle(1);
    check("p_first_err", 32'(err_cnt - e0), 32'd1);
    e0 = err_cnt;
    send_byte(8'h41);
    check("unk_rec_err", 32'(bus.rec_err), 32'd1);
    send_rec("x\n", 0);
    send_rec("S\n", 0);
    send_rec("\n", 0);
    idle(2);
    check("unk_empty_err_cnt", 32'(err_cnt - e0), 32'd1);
    check("misc_no_strobes", 32'(strobe_cnt - s0), 32'd0);
    check("misc_idle_busy", 32'(bus.busy), 32'd0);

    // 33-byte string overflows.
    s0 = strobe_cnt;
    e0 = err_cnt;
    send_byte(CH_STR);
    for (int i = 0; i < 33; i++) send_byte(8'(8'h30 + i % 10));
    send_byte(CH_TERM);
    idle(2);
    check("ovf_err_cnt", 32'(err_cnt - e0), 32'd1);
    check("ovf_no_strobes", 32'(strobe_cnt - s0), 32'd0);

    // String with input stalls.
    s0 = strobe_cnt;
    exp_q = '{8'h61, 8'h62, 8'h63, CH_SPACE, 8'h64};
    send_rec("Sabc d\n", 1);
    check_burst("str1", 1'b0, 5, 1'b0);
    check("str1_strobe_cnt", 32'(strobe_cnt - s0), 32'd5);
    check("str1_ready_after", 32'(bus.in_ready), 32'd1);

    // Pattern with stalls, then WAIT.
    exp_q = '{8'h63, CH_ANY, 8'h64};
    send_rec("Pc.d\n", 1);
    check_burst("pat1", 1'b1, 3, 1'b0);
    wait_release("pat1");

    exp_q = '{8'h78, 8'h79};
    send_rec("Sxy\n", 0);
    check_burst("str2", 1'b0, 2, 1'b0);

    // Second string without a pattern in between.
    s0 = strobe_cnt;
    e0 = err_cnt;
    send_rec("Sq\n", 0);
    idle(1);
    check("s_after_s_err", 32'(err_cnt - e0), 32'd1);
    check("s_after_s_no_strobes", 32'(strobe_cnt - s0), 32'd0);

    // Three patterns back-to-back, sme_valid held during each PLAY.
    exp_q = '{CH_ANY, 8'h61};
    send_rec("P.a\n", 0);
    check_burst("patA", 1'b1, 2, 1'b1);
    wait_release("patA");
    exp_q = '{8'h62, CH_STAR};
    send_rec("Pb*\n", 0);
    check_burst("patB", 1'b1, 2, 1'b1);
    wait_release("patB");
    exp_q = '{CH_BOL, 8'h63, CH_EOL};
    send_rec("P^c$\n", 0);
    check_burst("patC", 1'b1, 3, 1'b1);
    wait_release("patC");

    // Reset in the second PLAY cycle.
    send_rec("Sabcd\n", 0);
    check("play1_data", 32'(bus.chardata), 32'h61);
    idle(1);
    check("play2_data", 32'(bus.chardata), 32'h62);
    reset = 1'b0;
    #1;
    check("midrst_outputs", 32'({bus.chardata, bus.isstring, bus.ispattern, bus.busy, bus.rec_err}), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    idle(2);
    reset = 1'b1;
    #1;
    check("midrst_rel_ready", 32'(bus.in_ready), 32'd1);
    s0 = strobe_cnt;
    e0 = err_cnt;
    send_rec("Pz\n", 0);
    idle(1);
    check("midrst_p_err", 32'(err_cnt - e0), 32'd1);
    check("midrst_p_no_strobes", 32'(strobe_cnt - s0), 32'd0);

    check("never_both_strobes", 32'(both_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
